// File: rtl/rename_map_ckpt_pkg.sv
// Shared sizing, checkpoint record type and helpers for the rename unit.
package rename_map_ckpt_pkg;

  localparam int unsigned NUM_LOG   = 32;
  localparam int unsigned NUM_PHY   = 64;
  // NUM_CKPT must be a power of two, at least 2, so the pointers wrap naturally.
  localparam int unsigned NUM_CKPT  = 4;
  localparam int unsigned ROB_TAG_W = 6;

  localparam int unsigned LW = $clog2(NUM_LOG);
  localparam int unsigned PW = $clog2(NUM_PHY);
  localparam int unsigned CW = $clog2(NUM_CKPT);

  typedef logic [NUM_LOG-1:0][PW-1:0] map_t;

  // A snapshot of the map plus every register allocated since it was taken.
  typedef struct packed {
    map_t               map;
    logic [NUM_PHY-1:0] alloc_mask;
  } ckpt_t;

  function automatic logic [PW:0] popcount(input logic [NUM_PHY-1:0] v);
    logic [PW:0] n;
    n = '0;
    for (int unsigned i = 0; i < NUM_PHY; i++) n += (PW+1)'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/rename_map_ckpt_if.sv
// Decode/rename/writeback/commit/branch signal bundle for the rename unit.
interface rename_map_ckpt_if;
  import rename_map_ckpt_pkg::*;

  logic                 ren_valid;
  logic                 ren_uses_rw;
  logic [LW-1:0]        ren_rs;
  logic [LW-1:0]        ren_rt;
  logic [LW-1:0]        ren_rw;
  logic [ROB_TAG_W-1:0] ren_rob_tag;
  logic                 ren_ckpt;
  logic                 ren_stall;
  logic [PW-1:0]        rs_phy;
  logic [PW-1:0]        rt_phy;
  logic                 rs_ready;
  logic                 rt_ready;
  logic [ROB_TAG_W-1:0] rs_tag;
  logic [ROB_TAG_W-1:0] rt_tag;
  logic [PW-1:0]        rw_phy;
  logic [PW-1:0]        rw_old_phy;
  logic                 wb_en;
  logic [PW-1:0]        wb_phy;
  logic                 commit_en;
  logic [PW-1:0]        commit_old_phy;
  logic                 br_ok;
  logic                 br_mispredict;
  logic [CW:0]          ckpt_count;
  logic [PW:0]          free_count;

  modport master (
    output ren_valid, ren_uses_rw, ren_rs, ren_rt, ren_rw, ren_rob_tag, ren_ckpt,
    output wb_en, wb_phy, commit_en, commit_old_phy, br_ok, br_mispredict,
    input  ren_stall, rs_phy, rt_phy, rs_ready, rt_ready, rs_tag, rt_tag,
    input  rw_phy, rw_old_phy, ckpt_count, free_count
  );

  modport slave (
    input  ren_valid, ren_uses_rw, ren_rs, ren_rt, ren_rw, ren_rob_tag, ren_ckpt,
    input  wb_en, wb_phy, commit_en, commit_old_phy, br_ok, br_mispredict,
    output ren_stall, rs_phy, rt_phy, rs_ready, rt_ready, rs_tag, rt_tag,
    output rw_phy, rw_old_phy, ckpt_count, free_count
  );

endinterface

// File: rtl/rename_map_ckpt_free_pick.sv
// Lowest-set-bit priority encoder used to choose the next free physical register.
module rename_map_ckpt_free_pick #(
  parameter int unsigned N = 64
) (
  input  logic [N-1:0]         req,
  output logic [$clog2(N)-1:0] idx,
  output logic                 avail
);

  localparam int unsigned W = $clog2(N);

  // Scan high to low so the last hit written is the lowest index.
  always_comb begin
    idx   = '0;
    avail = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = W'(i);
        avail = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rename_map_ckpt.sv
// Register rename unit: map table, free/ready/tag tracking and a branch checkpoint FIFO.
module rename_map_ckpt
  import rename_map_ckpt_pkg::*;
(
  input logic              clk,
  input logic              rst_n,
  rename_map_ckpt_if.slave bus
);

  map_t                 map_q, map_d, map_ren;
  logic [NUM_PHY-1:0]   free_q, free_d, ready_q, ready_d;
  logic [ROB_TAG_W-1:0] tag_q [NUM_PHY];
  ckpt_t                ckpt_q [NUM_CKPT];
  ckpt_t                ckpt_d [NUM_CKPT];
  logic [CW-1:0]        head_q, head_d, tail_q, tail_d;
  logic [CW:0]          count_q, count_d;
  logic [PW:0]          free_cnt_q;
  logic [NUM_CKPT-1:0]  live;

  logic          need_rw, fire, alloc, push, pop, mis_live, pick_avail;
  logic [PW-1:0] pick_idx, rw_phy, rs_phy, rt_phy;

  rename_map_ckpt_free_pick #(
    .N (NUM_PHY)
  ) u_free_pick (
    .req   (free_q),
    .idx   (pick_idx),
    .avail (pick_avail)
  );

  // Handshake decode and combinational lookups.
  always_comb begin
    need_rw       = bus.ren_uses_rw && (bus.ren_rw != '0);
    bus.ren_stall = bus.ren_valid &&
                    ((need_rw && (free_cnt_q == '0)) ||
                     (bus.ren_ckpt && (count_q == (CW+1)'(NUM_CKPT))));
    fire          = bus.ren_valid && !bus.ren_stall && !bus.br_mispredict;
    alloc         = fire && need_rw;
    push          = fire && bus.ren_ckpt;
    mis_live      = bus.br_mispredict && (count_q != '0);
    pop           = bus.br_ok && (count_q != '0);
    rw_phy        = (need_rw && pick_avail) ? pick_idx : '0;
    rs_phy        = map_q[bus.ren_rs];
    rt_phy        = map_q[bus.ren_rt];
    bus.rw_phy     = rw_phy;
    bus.rw_old_phy = map_q[bus.ren_rw];
    bus.rs_phy     = rs_phy;
    bus.rt_phy     = rt_phy;
    // Same-cycle writeback bypass so a just-completed producer reads as ready.
    bus.rs_ready   = ready_q[rs_phy] || (bus.wb_en && (bus.wb_phy == rs_phy));
    bus.rt_ready   = ready_q[rt_phy] || (bus.wb_en && (bus.wb_phy == rt_phy));
    bus.rs_tag     = tag_q[rs_phy];
    bus.rt_tag     = tag_q[rt_phy];
    bus.ckpt_count = count_q;
    bus.free_count = free_cnt_q;
  end

  // Mark which FIFO slots hold live checkpoints, walking forward from head.
  always_comb begin
    live = '0;
    for (int unsigned i = 0; i < NUM_CKPT; i++) begin
      if ((CW+1)'(i) < count_q) live[head_q + CW'(i)] = 1'b1;
    end
  end

  // Next map, free and ready state; mispredict restore wins over the rename.
  always_comb begin
    map_ren = map_q;
    if (alloc) map_ren[bus.ren_rw] = rw_phy;
    map_d   = mis_live ? ckpt_q[head_q].map : map_ren;
    free_d  = free_q;
    ready_d = ready_q;
    if (alloc) begin
      free_d[rw_phy]  = 1'b0;
      ready_d[rw_phy] = 1'b0;
    end
    if (mis_live) begin
      free_d  = free_d | ckpt_q[head_q].alloc_mask;
      ready_d = ready_d | ckpt_q[head_q].alloc_mask;
    end
    if (bus.wb_en) ready_d[bus.wb_phy] = 1'b1;
    if (bus.commit_en) free_d[bus.commit_old_phy] = 1'b1;
    // p0 is the permanent home of r0.
    free_d[0]  = 1'b0;
    ready_d[0] = 1'b1;
  end

  // Checkpoint FIFO: mask accumulation, push at tail, pop at head, flush on mispredict.
  always_comb begin
    ckpt_d = ckpt_q;
    for (int unsigned c = 0; c < NUM_CKPT; c++) begin
      if (alloc && live[c]) ckpt_d[c].alloc_mask[rw_phy] = 1'b1;
    end
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (mis_live) begin
      head_d  = tail_q;
      count_d = '0;
    end else begin
      if (push) begin
        ckpt_d[tail_q].map        = map_ren;
        ckpt_d[tail_q].alloc_mask = '0;
        tail_d                    = tail_q + CW'(1);
      end
      if (pop) head_d = head_q + CW'(1);
      count_d = count_q + (CW+1)'(push) - (CW+1)'(pop);
    end
  end

  // Architectural state with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_LOG; i++) map_q[i] <= PW'(i);
      free_q     <= {{(NUM_PHY-NUM_LOG){1'b1}}, {NUM_LOG{1'b0}}};
      ready_q    <= '1;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      free_cnt_q <= (PW+1)'(NUM_PHY - NUM_LOG);
    end else begin
      map_q      <= map_d;
      free_q     <= free_d;
      ready_q    <= ready_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      free_cnt_q <= popcount(free_d);
    end
  end

  // Producer ROB tag per physical register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_PHY; i++) tag_q[i] <= '0;
    end else if (alloc) begin
      tag_q[rw_phy] <= bus.ren_rob_tag;
    end
  end

  // Checkpoint payload needs no reset: slots are only read while live.
  always_ff @(posedge clk) begin
    ckpt_q <= ckpt_d;
  end

endmodule

// File: tb/tb_rename_map_ckpt.sv
// Self-checking bench for rename_map_ckpt: vector table plus hand-built sequences.
module tb_rename_map_ckpt;
  import rename_map_ckpt_pkg::*;

  typedef struct {
    int valid, uses_rw, rw, rs, rt, ckpt, wb_en, wb_phy, commit_en, commit_phy, br_ok, br_mis;
  } in_t;
  typedef struct {
    int stall, rw_phy, rw_old, rs_phy, rs_rdy, rt_phy, rt_rdy, free_cnt, ckpt_cnt, rs_tag;
  } exp_t;
  typedef struct {
    in_t  i;
    exp_t e;
  } vec_t;
  typedef struct {
    string nm;
    int    free_cnt;
    int    ckpt_cnt;
  } sb_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   step;
  vec_t tbl[$];
  sb_t  sb_q[$];

  rename_map_ckpt_if bus ();

  rename_map_ckpt dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input in_t i);
    bus.ren_valid      = 1'(i.valid);
    bus.ren_uses_rw    = 1'(i.uses_rw);
    bus.ren_rw         = LW'(i.rw);
    bus.ren_rs         = LW'(i.rs);
    bus.ren_rt         = LW'(i.rt);
    bus.ren_ckpt       = 1'(i.ckpt);
    bus.ren_rob_tag    = ROB_TAG_W'(step);
    bus.wb_en          = 1'(i.wb_en);
    bus.wb_phy         = PW'(i.wb_phy);
    bus.commit_en      = 1'(i.commit_en);
    bus.commit_old_phy = PW'(i.commit_phy);
    bus.br_ok          = 1'(i.br_ok);
    bus.br_mispredict  = 1'(i.br_mis);
  endtask

  task automatic idle();
    in_t z;
    z = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    drive(z);
  endtask

  // Combinational outputs checked mid-cycle; registered counts queued and checked after the edge.
  task automatic apply(input in_t i, input exp_t e, input string nm);
    sb_t s;
    @(negedge clk);
    drive(i);
    #1;
    chk({nm, " stall"}, int'(bus.ren_stall), e.stall);
    chk({nm, " rw_phy"}, int'(bus.rw_phy), e.rw_phy);
    chk({nm, " rw_old_phy"}, int'(bus.rw_old_phy), e.rw_old);
    chk({nm, " rs_phy"}, int'(bus.rs_phy), e.rs_phy);
    chk({nm, " rs_ready"}, int'(bus.rs_ready), e.rs_rdy);
    chk({nm, " rt_phy"}, int'(bus.rt_phy), e.rt_phy);
    chk({nm, " rt_ready"}, int'(bus.rt_ready), e.rt_rdy);
    if (e.rs_tag >= 0) chk({nm, " rs_tag"}, int'(bus.rs_tag), e.rs_tag);
    sb_q.push_back('{nm, e.free_cnt, e.ckpt_cnt});
    @(posedge clk);
    #1;
    s = sb_q.pop_front();
    chk({s.nm, " free_count"}, int'(bus.free_count), s.free_cnt);
    chk({s.nm, " ckpt_count"}, int'(bus.ckpt_count), s.ckpt_cnt);
    step++;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    step     = 1;
    rst_n    = 1'b0;
    idle();
    bus.ren_rs = LW'(7);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset ren_stall", int'(bus.ren_stall), 0);
    chk("reset free_count", int'(bus.free_count), NUM_PHY - NUM_LOG);
    chk("reset ckpt_count", int'(bus.ckpt_count), 0);
    chk("reset map r7", int'(bus.rs_phy), 7);
    chk("reset ready r7", int'(bus.rs_ready), 1);

    // in:  valid uses_rw rw rs rt ckpt wb_en wb_phy commit_en commit_phy br_ok br_mis
    // exp: stall rw_phy rw_old rs_phy rs_rdy rt_phy rt_rdy free ckpt rs_tag(-1 = skip)
    tbl.push_back('{'{1, 1, 5, 5, 6, 0, 0, 0, 0, 0, 0, 0}, '{0, 32, 5, 5, 1, 6, 1, 31, 0, 0}});
    tbl.push_back('{'{1, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 32, 0, 0, 1, 31, 0, 1}});
    tbl.push_back('{'{1, 1, 0, 5, 0, 0, 1, 32, 0, 0, 0, 0}, '{0, 0, 0, 32, 1, 0, 1, 31, 0, 1}});
    tbl.push_back('{'{1, 1, 6, 5, 0, 0, 0, 0, 0, 0, 0, 0}, '{0, 33, 6, 32, 1, 0, 1, 30, 0, -1}});
    tbl.push_back('{'{1, 0, 0, 6, 5, 0, 1, 33, 0, 0, 0, 0}, '{0, 0, 0, 33, 1, 32, 1, 30, 0, 4}});
    tbl.push_back('{'{1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 1, 0, 1, 30, 1, -1}});
    tbl.push_back('{'{1, 1, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0}, '{0, 34, 3, 3, 1, 0, 1, 29, 1, -1}});
    tbl.push_back('{'{1, 1, 4, 4, 0, 0, 0, 0, 0, 0, 0, 0}, '{0, 35, 4, 4, 1, 0, 1, 28, 1, -1}});
    tbl.push_back('{'{1, 1, 7, 3, 4, 0, 0, 0, 0, 0, 0, 1}, '{0, 36, 7, 34, 0, 35, 0, 30, 0, -1}});
    tbl.push_back('{'{1, 1, 7, 3, 4, 0, 0, 0, 0, 0, 0, 0}, '{0, 34, 7, 3, 1, 4, 1, 29, 0, -1}});
    foreach (tbl[k]) apply(tbl[k].i, tbl[k].e, $sformatf("vec%0d", k));

    // Exhaust the free list by repeatedly renaming r8.
    for (int k = 0; k < 29; k++) begin
      apply('{1, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0},
            '{0, 35 + k, (k == 0) ? 8 : 34 + k, 0, 1, 0, 1, 28 - k, 0, -1},
            $sformatf("fill%0d", k));
    end
    apply('{1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0}, '{1, 0, 9, 0, 1, 0, 1, 0, 0, -1}, "full_stall");
    apply('{1, 0, 0, 9, 0, 0, 0, 0, 1, 7, 0, 0}, '{0, 0, 0, 9, 1, 0, 1, 1, 0, -1}, "commit7");
    apply('{1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0}, '{0, 7, 9, 0, 1, 0, 1, 0, 0, -1}, "reuse7");
    for (int k = 0; k < 4; k++) begin
      apply('{0, 0, 0, 0, 0, 0, 0, 0, 1, 35 + k, 0, 0}, '{0, 0, 0, 0, 1, 0, 1, 1 + k, 0, -1},
            $sformatf("commit%0d", 35 + k));
    end

    // Fill the checkpoint FIFO, then pop/push across the wrap and mispredict to the oldest.
    apply('{1, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0}, '{0, 35, 1, 0, 1, 0, 1, 3, 1, -1}, "ck1");
    apply('{1, 1, 2, 0, 0, 1, 0, 0, 0, 0, 0, 0}, '{0, 36, 2, 0, 1, 0, 1, 2, 2, -1}, "ck2");
    apply('{1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 1, 0, 1, 2, 3, -1}, "ck3");
    apply('{1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 1, 0, 1, 2, 4, -1}, "ck4");
    apply('{1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0}, '{1, 0, 0, 0, 1, 0, 1, 2, 4, -1}, "ck5_stall");
    apply('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0}, '{0, 0, 0, 0, 1, 0, 1, 2, 3, -1}, "br_ok");
    apply('{1, 1, 10, 0, 0, 1, 0, 0, 0, 0, 1, 0}, '{0, 37, 10, 0, 1, 0, 1, 1, 3, -1}, "ok_push1");
    apply('{1, 1, 11, 0, 0, 1, 0, 0, 0, 0, 1, 0}, '{0, 38, 11, 0, 1, 0, 1, 0, 3, -1}, "ok_push2");
    apply('{1, 0, 0, 10, 11, 0, 0, 0, 0, 0, 0, 1}, '{0, 0, 0, 37, 0, 38, 0, 2, 0, -1}, "mis_wrap");
    apply('{1, 1, 12, 10, 1, 0, 0, 0, 0, 0, 0, 0}, '{0, 37, 12, 10, 1, 35, 0, 1, 0, -1}, "post_mis");

    // Mispredict, commit and rename in one cycle.
    apply('{1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 1, 0, 1, 1, 1, -1}, "ck6");
    apply('{1, 1, 13, 0, 0, 0, 0, 0, 1, 39, 0, 0}, '{0, 38, 13, 0, 1, 0, 1, 1, 1, -1}, "ren13");
    apply('{1, 1, 14, 0, 0, 0, 0, 0, 1, 10, 0, 1}, '{0, 39, 14, 0, 1, 0, 1, 3, 0, -1}, "mis_cm");
    apply('{1, 1, 15, 13, 14, 0, 0, 0, 0, 0, 0, 0}, '{0, 10, 15, 13, 1, 14, 1, 2, 0, -1}, "reuse10");
    apply('{1, 1, 16, 0, 0, 0, 0, 0, 0, 0, 0, 1}, '{0, 38, 16, 0, 1, 0, 1, 2, 0, -1}, "mis_empty");
    apply('{1, 1, 16, 0, 0, 1, 0, 0, 0, 0, 1, 0}, '{0, 38, 16, 0, 1, 0, 1, 1, 1, -1}, "ok_empty");

    // Reset with a live checkpoint discards it.
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midreset ckpt_count", int'(bus.ckpt_count), 0);
    chk("midreset free_count", int'(bus.free_count), NUM_PHY - NUM_LOG);
    @(negedge clk);
    rst_n = 1'b1;
    apply('{1, 0, 0, 16, 12, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 16, 1, 12, 1, 32, 0, 0}, "after_rst");
    apply('{0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 1}, '{0, 0, 0, 5, 1, 0, 1, 32, 0, -1}, "rst_mis");

    @(negedge clk);
    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
